// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow complete right after accept.
module exu_div #(
    parameter int XLEN                = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           div_valid,
    input  logic                           div_signed,
    input  logic                           div_rem,
    input  logic [XLEN-1:0]                rs1_data,
    input  logic [XLEN-1:0]                rs2_data,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr,
    input  logic [31:0]                    instr_tag,
    input  logic                           flush,
    output logic                           div_busy,
    output logic                           wb_valid,
    output logic [XLEN-1:0]                wb_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_addr,
    output logic [31:0]                    wb_instr_tag
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [XLEN-1:0]                dvd_q, dvd_d;
    logic [XLEN-1:0]                dvs_q, dvs_d;
    logic [XLEN-1:0]                rem_q, rem_d;
    logic [XLEN-1:0]                wb_data_q, wb_data_d;
    logic                           qneg_q, qneg_d;
    logic                           rneg_q, rneg_d;
    logic                           sel_rem_q, sel_rem_d;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [31:0]                    tag_q, tag_d;

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          a_neg, b_neg, div0, ovf;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + XLEN'(1)) : v;
    endfunction

    assign a_neg   = div_signed & rs1_data[XLEN-1];
    assign b_neg   = div_signed & rs2_data[XLEN-1];
    assign div0    = (rs2_data == '0);
    assign ovf     = div_signed && (rs1_data == INT_MIN) && (rs2_data == '1);
    // Remainder stays below the divisor, so the XLEN+1-bit trial's MSB is its sign.
    assign shifted = {rem_q, dvd_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        wb_data_d = wb_data_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        sel_rem_d = sel_rem_q;
        rd_d      = rd_q;
        tag_d     = tag_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_valid) begin
                        rd_d      = rd_addr;
                        tag_d     = instr_tag;
                        sel_rem_d = div_rem;
                        qneg_d    = a_neg ^ b_neg;
                        rneg_d    = a_neg;
                        if (div0) begin
                            wb_data_d = div_rem ? rs1_data : '1;
                            state_d   = DONE;
                        end else if (ovf) begin
                            wb_data_d = div_rem ? '0 : INT_MIN;
                            state_d   = DONE;
                        end else begin
                            dvd_d   = cond_neg(rs1_data, a_neg);
                            dvs_d   = cond_neg(rs2_data, b_neg);
                            rem_d   = '0;
                            cnt_d   = '0;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], ~trial[XLEN]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) state_d = FIX;
                end
                FIX: begin
                    wb_data_d = sel_rem_q ? cond_neg(rem_q, rneg_q) : cond_neg(dvd_q, qneg_q);
                    state_d   = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            wb_data_q <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            rd_q      <= '0;
            tag_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            wb_data_q <= wb_data_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            sel_rem_q <= sel_rem_d;
            rd_q      <= rd_d;
            tag_q     <= tag_d;
        end
    end

    assign div_busy     = (state_q != IDLE);
    assign wb_valid     = (state_q == DONE);
    assign wb_data      = wb_data_q;
    assign wb_rd_addr   = rd_q;
    assign wb_instr_tag = tag_q;
endmodule
